// File: rtl/fpga_cfg_loader.sv
// Configuration bitstream loader: SYNC word, payload words, checksum word over valid/ready.
// The fabric configuration vector is only committed after the checksum matches.
module fpga_cfg_loader #(
  parameter int              DIN_W    = 8,
  parameter int              CFG_BITS = 12038,
  parameter logic [DIN_W-1:0] SYNC    = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIN_W-1:0]    din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [CFG_BITS-1:0] cfg,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                busy
);

  localparam int NWORDS = (CFG_BITS + DIN_W - 1) / DIN_W;
  localparam int SHW    = NWORDS * DIN_W;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t              state_r, next_state_s;
  logic [SHW-1:0]      shift_r;
  logic [DIN_W-1:0]    acc_r;
  logic [CW-1:0]       cnt_r;
  logic                match_r;
  logic [CFG_BITS-1:0] cfg_r;
  logic                done_r, error_r, ready_r, busy_r;
  logic                ready_nxt_s, busy_nxt_s, beat_s;

  function automatic logic [DIN_W-1:0] chk_fold(input logic [DIN_W-1:0] acc,
                                                input logic [DIN_W-1:0] word);
    return acc ^ word;
  endfunction

  assign beat_s    = din_valid & ready_r;
  assign din_ready = ready_r;
  assign busy      = busy_r;
  assign cfg       = cfg_r;
  assign cfg_done  = done_r;
  assign cfg_error = error_r;

  // State register plus registered handshake/status flags decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (beat_s && (din == SYNC)) next_state_s = LOAD;  else next_state_s = IDLE;
      LOAD:    if (beat_s && (cnt_r == LAST)) next_state_s = CHECK; else next_state_s = LOAD;
      CHECK:   if (beat_s) next_state_s = COMMIT; else next_state_s = CHECK;
      COMMIT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode for the upcoming state; COMMIT is the only cycle that refuses input
  always_comb begin
    ready_nxt_s = 1'b1;
    busy_nxt_s  = 1'b0;
    case (next_state_s)
      IDLE:    begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
      LOAD:    begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b1; end
      CHECK:   begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b1; end
      COMMIT:  begin ready_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
      default: begin ready_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
    endcase
  end

  // Datapath: payload assembly, running checksum and atomic commit of cfg
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      match_r <= 1'b0;
      cfg_r   <= '0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (beat_s && (din == SYNC)) begin
            acc_r   <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
          end
        end
        LOAD: begin
          if (beat_s) begin
            // First word ends up at the LSB once all NWORDS have been shifted in
            shift_r <= {din, shift_r[SHW-1:DIN_W]};
            acc_r   <= chk_fold(acc_r, din);
            if (cnt_r != LAST) cnt_r <= cnt_r + CW'(1);
          end
        end
        CHECK: begin
          if (beat_s) match_r <= (din == acc_r);
        end
        COMMIT: begin
          if (match_r) begin
            cfg_r  <= shift_r[CFG_BITS-1:0];
            done_r <= 1'b1;
          end else begin
            error_r <= 1'b1;
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader at DIN_W=8, CFG_BITS=20 (three payload words).
// Expected commit results are queued by the stimulus and checked by a monitor on each commit.
module tb_fpga_cfg_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [19:0] cfg;
  logic        cfg_done, cfg_error, busy;

  typedef struct packed {
    logic [19:0] cfg;
    logic        done;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fpga_cfg_loader #(.DIN_W(8), .CFG_BITS(20), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .cfg(cfg), .cfg_done(cfg_done), .cfg_error(cfg_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One beat, waiting (bounded) for din_ready, then 'gap' idle cycles
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    din = b;
    din_valid = 1'b1;
    while (!din_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic stream(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                        input logic [7:0] chk, input exp_t e, input int gap);
    exp_q.push_back(e);
    send(8'hA5, gap);
    send(w0, gap);
    send(w1, gap);
    send(w2, gap);
    send(chk, gap);
    @(posedge clk); #1;
  endtask

  // Monitor: every rising edge of cfg_done|cfg_error is one commit result
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if ((cfg_done | cfg_error) && !prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("commit_cfg", 32'(cfg), 32'(e.cfg));
          check("commit_done", 32'(cfg_done), 32'(e.done));
          check("commit_error", 32'(cfg_error), 32'(e.err));
          check("commit_busy", 32'(busy), 32'd0);
        end
      end
      prev = cfg_done | cfg_error;
    end
  end

  initial begin
    int n;
    // Reset state
    do_reset();
    check("rst_cfg", 32'(cfg), 32'h0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_error", 32'(cfg_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);

    // 1: good load
    stream(8'h01, 8'h02, 8'h03, 8'h00, '{cfg: 20'h30201, done: 1'b1, err: 1'b0}, 0);

    // 2: bad checksum after reset, cfg stays 0
    do_reset();
    stream(8'h01, 8'h02, 8'h03, 8'hFF, '{cfg: 20'h00000, done: 1'b0, err: 1'b1}, 0);

    // 3: leading garbage is discarded
    do_reset();
    send(8'h00, 0); check("garbage_busy0", 32'(busy), 32'd0);
    send(8'h11, 0); check("garbage_busy1", 32'(busy), 32'd0);
    send(8'h5A, 0); check("garbage_busy2", 32'(busy), 32'd0);
    stream(8'h01, 8'h02, 8'h03, 8'h00, '{cfg: 20'h30201, done: 1'b1, err: 1'b0}, 0);

    // 4: stalls between beats, valid held high across COMMIT
    do_reset();
    exp_q.push_back('{cfg: 20'h30201, done: 1'b1, err: 1'b0});
    send(8'hA5, 3);
    send(8'h01, 3);
    send(8'h02, 3);
    check("stall_ready", 32'(din_ready), 32'd1);
    send(8'h03, 3);
    din = 8'h00;
    din_valid = 1'b1;
    @(posedge clk); #1;
    check("commit_ready_low", 32'(din_ready), 32'd0);
    check("commit_busy_high", 32'(busy), 32'd1);
    din = 8'h3C;
    @(posedge clk); #1;
    check("post_commit_ready", 32'(din_ready), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    check("post_commit_idle", 32'(busy), 32'd0);

    // 5: reset mid-load clears cfg, then a fresh load (0F^F0^0A = F5)
    send(8'hA5, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    check("midload_busy", 32'(busy), 32'd1);
    do_reset();
    check("midreset_cfg", 32'(cfg), 32'h0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(cfg_done), 32'd0);
    stream(8'h0F, 8'hF0, 8'h0A, 8'hF5, '{cfg: 20'hAF00F, done: 1'b1, err: 1'b0}, 0);

    // 6: reload keeps old cfg until the new commit
    do_reset();
    stream(8'h01, 8'h02, 8'h03, 8'h00, '{cfg: 20'h30201, done: 1'b1, err: 1'b0}, 0);
    exp_q.push_back('{cfg: 20'h02010, done: 1'b1, err: 1'b0});
    send(8'hA5, 0);
    check("reload_done_drop", 32'(cfg_done), 32'd0);
    check("reload_cfg_hold0", 32'(cfg), 32'h30201);
    send(8'h10, 0);
    send(8'h20, 0);
    send(8'h30, 0);
    check("reload_cfg_hold1", 32'(cfg), 32'h30201);
    send(8'h00, 0);
    check("reload_cfg_hold2", 32'(cfg), 32'h30201);
    @(posedge clk); #1;

    // Drain the scoreboard with a bounded wait
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
